// File: rtl/fiapp_param.sv
// fiapp_param: parametrised fault-injection target.
// Contains a single-bit register path, a wide run counter with a forced sticky
// bit, NUM_CH x DEPTH delay-line arrays and a small IDLE/RUN/DRAIN FSM.
// Optional feature macro: FIAPP_PARITY_EN adds a per-stage even-parity bit and
// a sticky err flag. When it is undefined, err is tied to 0.
module fiapp_param #(
  parameter int CNT_W      = 65,  // must be >= NUM_CH*DATA_W
  parameter int DATA_W     = 3,
  parameter int DEPTH      = 2,   // must be >= 1
  parameter int NUM_CH     = 2,
  parameter int STICKY_BIT = 32   // must be < CNT_W
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     a,
  input  logic                     enable,
  input  logic                     start,
  input  logic                     stop,
  output logic                     o1,
  output logic                     o2,
  output logic                     o3,
  output logic [CNT_W-1:0]         cnt_o,
  output logic [NUM_CH*DATA_W-1:0] tap_o,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  localparam int DCW = $clog2(DEPTH + 1);
  localparam logic [DCW-1:0]   DRAIN_LAST  = DCW'(DEPTH - 1);
  localparam logic [CNT_W-1:0] STICKY_MASK = CNT_W'(1) << STICKY_BIT;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  logic q1, q2, q3;
  state_t state_q, state_d;
  logic [DCW-1:0] drain_cnt_q, drain_cnt_d;
  logic busy_q, done_q;
  logic [CNT_W-1:0] cnt_q;
  logic [DATA_W-1:0] stage [NUM_CH][DEPTH];
  logic [DATA_W-1:0] stage_in [NUM_CH];

  // Bit path: runs regardless of FSM state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q1 <= 1'b0;
      q2 <= 1'b0;
      q3 <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking (<=) so every flop samples
      // pre-edge values; blocking here would make q2 see the new q1.
      if (enable) q1 <= a;
      q2 <= q1;
      q3 <= !q1;
    end
  end

  // FSM next-state and drain-counter logic.
  always_comb begin
    // NOTE: defaults first so every path assigns every output; a missing
    // branch would otherwise infer a latch.
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = RUN;
      end
      RUN: begin
        if (stop) begin
          state_d     = DRAIN;
          drain_cnt_d = '0;
        end
      end
      DRAIN: begin
        if (drain_cnt_q == DRAIN_LAST) begin
          state_d     = IDLE;
          drain_cnt_d = '0;
        end else begin
          drain_cnt_d = drain_cnt_q + DCW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state register plus registered busy/done decode.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      drain_cnt_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      busy_q      <= (state_d != IDLE);
      done_q      <= (state_q == DRAIN) && (state_d == IDLE);
    end
  end

  // Run counter: increments with the sticky bit forced in RUN, holds elsewhere.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (state_q == RUN) begin
      cnt_q <= (cnt_q + CNT_W'(1)) | STICKY_MASK;
    end
  end

  // Stage-0 load value: counter slice in RUN, zeros while draining.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      stage_in[c] = '0;
      if (state_q == RUN) stage_in[c] = cnt_q[DATA_W*c +: DATA_W];
    end
  end

  // Delay lines: shift in RUN and DRAIN, hold in IDLE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: this array is reset on purpose; every stage is injectable state
      // and must start from a known value. Plain storage arrays are usually
      // left unreset so they map onto RAM.
      for (int c = 0; c < NUM_CH; c++)
        for (int k = 0; k < DEPTH; k++)
          stage[c][k] <= '0;
    end else if (state_q != IDLE) begin
      for (int c = 0; c < NUM_CH; c++) begin
        stage[c][0] <= stage_in[c];
        for (int k = 1; k < DEPTH; k++)
          stage[c][k] <= stage[c][k-1];
      end
    end
  end

`ifdef FIAPP_PARITY_EN
  logic par [NUM_CH][DEPTH];
  logic err_q;
  logic par_bad;

  // Parity bits travel alongside the data in each stage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < NUM_CH; c++)
        for (int k = 0; k < DEPTH; k++)
          par[c][k] <= 1'b0;
    end else if (state_q != IDLE) begin
      for (int c = 0; c < NUM_CH; c++) begin
        par[c][0] <= ^stage_in[c];
        for (int k = 1; k < DEPTH; k++)
          par[c][k] <= par[c][k-1];
      end
    end
  end

  // Any tap whose data disagrees with its carried parity bit.
  always_comb begin
    par_bad = 1'b0;
    for (int c = 0; c < NUM_CH; c++)
      if ((^stage[c][DEPTH-1]) != par[c][DEPTH-1]) par_bad = 1'b1;
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_q <= 1'b0;
    end else if (busy_q && par_bad) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  for (genvar c = 0; c < NUM_CH; c++) begin : g_tap
    assign tap_o[DATA_W*c +: DATA_W] = stage[c][DEPTH-1];
  end

  assign o1    = q1;
  assign o2    = q2;
  assign o3    = q3 & cnt_q[CNT_W-1];
  assign cnt_o = cnt_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_fiapp_param.sv
// Directed self-checking bench for fiapp_param: default instance plus an
// 8-bit counter instance used for the wrap sequence.
module tb_fiapp_param;

  logic clk = 1'b0;
  logic reset_n, a, enable, start, stop, start2, stop2;

  logic        o1, o2, o3, busy, done, err;
  logic [64:0] cnt_o;
  logic [5:0]  tap_o;

  logic        o1_2, o2_2, o3_2, busy2, done2, err2;
  logic [7:0]  cnt2;
  logic [5:0]  tap2;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  fiapp_param dut (
    .clk(clk), .reset_n(reset_n), .a(a), .enable(enable),
    .start(start), .stop(stop),
    .o1(o1), .o2(o2), .o3(o3), .cnt_o(cnt_o), .tap_o(tap_o),
    .busy(busy), .done(done), .err(err)
  );

  fiapp_param #(.CNT_W(8), .STICKY_BIT(7)) dut_w (
    .clk(clk), .reset_n(reset_n), .a(a), .enable(enable),
    .start(start2), .stop(stop2),
    .o1(o1_2), .o2(o2_2), .o3(o3_2), .cnt_o(cnt2), .tap_o(tap2),
    .busy(busy2), .done(done2), .err(err2)
  );

  task automatic check(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; a = 1'b0; enable = 1'b0;
    start = 1'b0; stop = 1'b0; start2 = 1'b0; stop2 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_o1", o1, 0);
    check("rst_cnt", cnt_o, 0);
    check("rst_tap", tap_o, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Bit path: o1 holds while enable is low.
    a = 1'b1; tick();
    check("hold_o1_a", o1, 0);
    a = 1'b0; tick();
    a = 1'b1; tick();
    check("hold_o1_b", o1, 0);
    enable = 1'b1; a = 1'b1; tick();
    check("load_o1", o1, 1);
    check("load_o2", o2, 0);
    enable = 1'b0; a = 1'b0; tick();
    check("delay_o1", o1, 1);
    check("delay_o2", o2, 1);
    check("o3_low", o3, 0);

    // Counter and delay line.
    start = 1'b1; tick();
    check("run_busy", busy, 1);
    check("run_cnt0", cnt_o, 0);
    start = 1'b0; tick();
    check("cnt1", cnt_o, 65'h1_0000_0001);
    check("tap_a", tap_o, 0);
    tick();
    check("cnt2", cnt_o, 65'h1_0000_0002);
    check("tap_b", tap_o, 0);
    tick();
    check("cnt3", cnt_o, 65'h1_0000_0003);
    check("tap_c", tap_o, 1);
    check("o3_run", o3, 0);
    stop = 1'b1; tick();
    check("cnt4", cnt_o, 65'h1_0000_0004);
    check("tap_d", tap_o, 2);
    check("stop_busy", busy, 1);
    check("stop_done", done, 0);
    stop = 1'b0; tick();
    check("drain1_tap", tap_o, 3);
    check("drain1_cnt", cnt_o, 65'h1_0000_0004);
    check("drain1_busy", busy, 1);
    check("drain1_done", done, 0);
    tick();
    check("drain2_tap", tap_o, 0);
    check("drain2_done", done, 1);
    check("drain2_busy", busy, 0);
    check("drain2_cnt", cnt_o, 65'h1_0000_0004);
    tick();
    check("idle_done", done, 0);
    check("idle_cnt", cnt_o, 65'h1_0000_0004);

    // start and stop together in IDLE go to RUN.
    start = 1'b1; stop = 1'b1; tick();
    check("both_busy", busy, 1);
    check("both_cnt", cnt_o, 65'h1_0000_0004);
    start = 1'b0; stop = 1'b0; tick();
    check("both_run_cnt", cnt_o, 65'h1_0000_0005);

    // Asynchronous reset mid-RUN.
    reset_n = 1'b0;
    #1;
    check("arst_o1", o1, 0);
    check("arst_o2", o2, 0);
    check("arst_cnt", cnt_o, 0);
    check("arst_tap", tap_o, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    check("post_rst_done_a", done, 0);
    check("post_rst_busy", busy, 0);
    tick();
    check("post_rst_done_b", done, 0);
    check("post_rst_cnt", cnt_o, 0);

    // Counter wrap on the 8-bit instance.
    start2 = 1'b1; tick();
    start2 = 1'b0;
    repeat (125) tick();
    check("wrap_fd", cnt2, 8'hFD);
    tick();
    check("wrap_fe", cnt2, 8'hFE);
    tick();
    check("wrap_ff", cnt2, 8'hFF);
    tick();
    check("wrap_80", cnt2, 8'h80);
    tick();
    check("wrap_81", cnt2, 8'h81);

`ifdef FIAPP_PARITY_EN
    start = 1'b1; tick();
    start = 1'b0; tick(); tick();
    check("par_clean", err, 0);
    dut.stage[1][0] = dut.stage[1][0] ^ 3'b001;
    tick(); tick();
    check("par_err", err, 1);
    repeat (3) tick();
    check("par_sticky", err, 1);
`else
    check("err_off", err, 0);
    check("err2_off", err2, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
